// File: rtl/can_bit_stuffer_pkg.sv
// Shared types and constants for the CAN transmit bit stuffer.
package can_bit_stuffer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        STUFF = 2'd2
    } can_stuff_state_t;

    localparam logic CAN_DOMINANT  = 1'b0;
    localparam logic CAN_RECESSIVE = 1'b1;
    localparam int   CAN_STUFF_LEN = 5;

endpackage

// File: rtl/can_run_counter.sv
// Run-length tracker for the stuffer: remembers the last bit inside the
// stuffing region and how many equal bits in a row have been sent.
// hit is combinational and flags that the bit being stepped in completes a run.
module can_run_counter
    import can_bit_stuffer_pkg::*;
#(
    parameter int STUFF_LEN = CAN_STUFF_LEN
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic step,
    input  logic din,
    input  logic qualify,
    input  logic load_stuff,
    output logic last_bit,
    output logic hit
);

    localparam int CW = $clog2(STUFF_LEN + 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    // Count the new bit: extend the run on a repeat, otherwise start a new one.
    always_comb begin
        cnt_nxt = '0;
        if (qualify) begin
            if ((din == last_bit) && (cnt != '0))
                cnt_nxt = cnt + CW'(1);
            else
                cnt_nxt = CW'(1);
        end
    end

    assign hit = step && qualify && (cnt_nxt == CW'(STUFF_LEN));

    // A stuff bit flips the tracked level and starts a fresh run of one.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            last_bit <= CAN_RECESSIVE;
        end else if (clear) begin
            cnt <= '0;
        end else if (load_stuff) begin
            cnt      <= CW'(1);
            last_bit <= ~last_bit;
        end else if (step) begin
            cnt <= cnt_nxt;
            if (qualify)
                last_bit <= din;
        end
    end

endmodule

// File: rtl/can_bit_stuffer.sv
// CAN transmit-side bit stuffer. Takes unstuffed frame bits one per bit time
// and inserts a complementary stuff bit after STUFF_LEN equal bits in the
// stuffing region. Define CAN_STUFF_CNT_EN to add a saturating stuff_count.
module can_bit_stuffer
    import can_bit_stuffer_pkg::*;
#(
    parameter int STUFF_LEN = CAN_STUFF_LEN
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       bit_tick,
    input  logic       frame_start,
    input  logic       in_valid,
    input  logic       in_bit,
    input  logic       in_stuff_en,
    input  logic       in_last,
    output logic       in_ready,
    output logic       tx_bit,
    output logic       tx_stuff,
    output logic       busy,
    output logic       underrun
`ifdef CAN_STUFF_CNT_EN
    ,
    output logic [7:0] stuff_count
`endif
);

    can_stuff_state_t state;
    logic stuff_pending;
    logic last_seen;

    logic xfer;
    logic rc_clear;
    logic rc_step;
    logic rc_load;
    logic rc_last;
    logic rc_hit;

    // Control strobes for the run tracker; frame_start overrides a same-cycle tick.
    always_comb begin
        xfer     = bit_tick && in_valid && in_ready && !stuff_pending;
        rc_clear = frame_start || ((state == DATA) && bit_tick && !in_valid);
        rc_step  = !frame_start && (state == DATA) && xfer;
        rc_load  = !frame_start && (state == STUFF) && bit_tick;
    end

    can_run_counter #(.STUFF_LEN(STUFF_LEN)) u_run (
        .clock      (clock),
        .reset      (reset),
        .clear      (rc_clear),
        .step       (rc_step),
        .din        (in_bit),
        .qualify    (in_stuff_en),
        .load_stuff (rc_load),
        .last_bit   (rc_last),
        .hit        (rc_hit)
    );

    // Frame FSM with registered outputs. Line values hold for a whole bit time;
    // IDLE returns the line to recessive at the next tick so the final bit
    // keeps its full width.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            stuff_pending <= 1'b0;
            last_seen     <= 1'b0;
            tx_bit        <= CAN_RECESSIVE;
            tx_stuff      <= 1'b0;
            in_ready      <= 1'b0;
            busy          <= 1'b0;
            underrun      <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (frame_start) begin
                state         <= DATA;
                stuff_pending <= 1'b0;
                last_seen     <= 1'b0;
                tx_stuff      <= 1'b0;
                in_ready      <= 1'b1;
                busy          <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (bit_tick) begin
                            tx_bit   <= CAN_RECESSIVE;
                            tx_stuff <= 1'b0;
                        end
                    end
                    DATA: begin
                        if (xfer) begin
                            tx_bit   <= in_bit;
                            tx_stuff <= 1'b0;
                            if (in_last)
                                last_seen <= 1'b1;
                            if (rc_hit) begin
                                stuff_pending <= 1'b1;
                                state         <= STUFF;
                                in_ready      <= 1'b0;
                            end else if (in_last) begin
                                state    <= IDLE;
                                in_ready <= 1'b0;
                                busy     <= 1'b0;
                            end
                        end else if (bit_tick && !in_valid) begin
                            tx_bit   <= CAN_RECESSIVE;
                            tx_stuff <= 1'b0;
                            underrun <= 1'b1;
                            state    <= IDLE;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                        end
                    end
                    STUFF: begin
                        if (bit_tick) begin
                            tx_bit        <= ~rc_last;
                            tx_stuff      <= 1'b1;
                            stuff_pending <= 1'b0;
                            if (last_seen) begin
                                state    <= IDLE;
                                in_ready <= 1'b0;
                                busy     <= 1'b0;
                            end else begin
                                state    <= DATA;
                                in_ready <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef CAN_STUFF_CNT_EN
    // Saturating count of stuff bits emitted in the current frame.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            stuff_count <= '0;
        else if (frame_start)
            stuff_count <= '0;
        else if (rc_load && (stuff_count != 8'hFF))
            stuff_count <= stuff_count + 8'd1;
    end
`endif

endmodule

// File: tb/tb_can_bit_stuffer.sv
// Randomized and directed bench for can_bit_stuffer against a stream model.
module tb_can_bit_stuffer;

    localparam int SL = 5;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic bit_tick = 1'b0;
    logic frame_start = 1'b0;
    logic in_valid = 1'b0;
    logic in_bit = 1'b0;
    logic in_stuff_en = 1'b0;
    logic in_last = 1'b0;
    logic in_ready;
    logic tx_bit;
    logic tx_stuff;
    logic busy;
    logic underrun;
`ifdef CAN_STUFF_CNT_EN
    logic [7:0] stuff_count;
`endif

    int errors = 0;
    int checks = 0;

    bit fb[64];
    bit fe[64];
    bit eb[$];
    bit es[$];

    can_bit_stuffer #(.STUFF_LEN(SL)) dut (
        .clock       (clock),
        .reset       (reset),
        .bit_tick    (bit_tick),
        .frame_start (frame_start),
        .in_valid    (in_valid),
        .in_bit      (in_bit),
        .in_stuff_en (in_stuff_en),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .tx_bit      (tx_bit),
        .tx_stuff    (tx_stuff),
        .busy        (busy),
        .underrun    (underrun)
`ifdef CAN_STUFF_CNT_EN
        ,
        .stuff_count (stuff_count)
`endif
    );

    always #5 clock = ~clock;

    // Expected line stream: every frame bit goes out; whenever the last SL
    // line bits sent inside the stuffing region are equal, a complement follows.
    function automatic void model(input int n);
        bit prev;
        int run;
        eb.delete();
        es.delete();
        prev = 1'b1;
        run  = 0;
        for (int j = 0; j < n; j++) begin
            eb.push_back(fb[j]);
            es.push_back(1'b0);
            if (fe[j]) begin
                run  = (run != 0 && fb[j] == prev) ? run + 1 : 1;
                prev = fb[j];
                if (run == SL) begin
                    eb.push_back(!prev);
                    es.push_back(1'b1);
                    prev = !prev;
                    run  = 1;
                end
            end else begin
                run = 0;
            end
        end
    endfunction

    task automatic pulse_start();
        @(negedge clock);
        frame_start = 1'b1;
        @(negedge clock);
        frame_start = 1'b0;
    endtask

    // One bit time; outputs are settled at the negedge after the tick.
    task automatic do_tick();
        @(negedge clock);
        bit_tick = 1'b1;
        @(negedge clock);
        bit_tick = 1'b0;
    endtask

    task automatic gap();
        repeat (2) @(negedge clock);
    endtask

    task automatic run_frame(input string nm, input int n);
        int i;
        bit rdy;
        model(n);
        pulse_start();
        i = 0;
        for (int k = 0; k < eb.size(); k++) begin
            if (i < n) begin
                in_valid    = 1'b1;
                in_bit      = fb[i];
                in_stuff_en = fe[i];
                in_last     = (i == n - 1);
            end else begin
                in_valid = 1'b0;
            end
            rdy = in_ready;
            checks++;
            if (rdy !== !es[k]) begin
                errors++;
                $display("FAIL %s in_ready k=%0d got %b exp %b", nm, k, rdy, !es[k]);
            end
            do_tick();
            checks++;
            if (tx_bit !== eb[k]) begin
                errors++;
                $display("FAIL %s tx_bit k=%0d got %b exp %b", nm, k, tx_bit, eb[k]);
            end
            checks++;
            if (tx_stuff !== es[k]) begin
                errors++;
                $display("FAIL %s tx_stuff k=%0d got %b exp %b", nm, k, tx_stuff, es[k]);
            end
            if (rdy && i < n) i++;
            gap();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_end got %b exp 0", nm, busy);
        end
        do_tick();
        checks++;
        if (tx_bit !== 1'b1 || tx_stuff !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_line got %b/%b exp 1/0", nm, tx_bit, tx_stuff);
        end
        gap();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if ({tx_bit, tx_stuff, in_ready, busy, underrun} !== 5'b10000) begin
            errors++;
            $display("FAIL reset outs got %b exp 10000",
                     {tx_bit, tx_stuff, in_ready, busy, underrun});
        end
`ifdef CAN_STUFF_CNT_EN
        checks++;
        if (stuff_count !== 8'd0) begin
            errors++;
            $display("FAIL reset stuff_count got %0d exp 0", stuff_count);
        end
`endif
    endtask

    task automatic test_directed();
        for (int j = 0; j < 6; j++) begin fb[j] = (j == 5); fe[j] = 1'b1; end
        run_frame("single_stuff", 6);
        for (int j = 0; j < 9; j++) begin fb[j] = (j >= 5); fe[j] = 1'b1; end
        run_frame("double_stuff", 9);
`ifdef CAN_STUFF_CNT_EN
        checks++;
        if (stuff_count !== 8'd2) begin
            errors++;
            $display("FAIL double_stuff stuff_count got %0d exp 2", stuff_count);
        end
`endif
        for (int j = 0; j < 7; j++) begin fb[j] = 1'b0; fe[j] = 1'b0; end
        run_frame("no_region", 7);
        for (int j = 0; j < 5; j++) begin fb[j] = 1'b1; fe[j] = 1'b1; end
        run_frame("stuff_after_last", 5);
    endtask

    task automatic test_underrun();
        pulse_start();
        in_valid = 1'b1; in_bit = 1'b0; in_stuff_en = 1'b1; in_last = 1'b0;
        do_tick();
        gap();
        in_valid = 1'b0;
        do_tick();
        checks++;
        if ({underrun, tx_bit, busy, in_ready} !== 4'b1100) begin
            errors++;
            $display("FAIL underrun pulse got %b exp 1100", {underrun, tx_bit, busy, in_ready});
        end
        @(negedge clock);
        checks++;
        if (underrun !== 1'b0) begin
            errors++;
            $display("FAIL underrun width got %b exp 0", underrun);
        end
        gap();
    endtask

    task automatic test_reset_mid_run();
        pulse_start();
        in_valid = 1'b1; in_bit = 1'b0; in_stuff_en = 1'b1; in_last = 1'b0;
        repeat (3) begin do_tick(); gap(); end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({tx_bit, tx_stuff, in_ready, busy, underrun} !== 5'b10000) begin
            errors++;
            $display("FAIL async_reset outs got %b exp 10000",
                     {tx_bit, tx_stuff, in_ready, busy, underrun});
        end
        @(negedge clock);
        reset = 1'b0;
        in_valid = 1'b0;
        for (int j = 0; j < 4; j++) begin fb[j] = 1'b0; fe[j] = 1'b1; end
        run_frame("after_reset", 4);
    endtask

    task automatic test_back_to_back();
        // Restart mid-run: history must not carry into the new frame.
        pulse_start();
        in_valid = 1'b1; in_bit = 1'b0; in_stuff_en = 1'b1; in_last = 1'b0;
        repeat (3) begin do_tick(); gap(); end
        in_valid = 1'b0;
        for (int j = 0; j < 6; j++) begin fb[j] = (j == 5); fe[j] = 1'b1; end
        fb[4] = 1'b1;
        run_frame("restart", 6);
    endtask

    task automatic test_random();
        int n, reg_end;
        bit b;
        for (int f = 0; f < 25; f++) begin
            n       = $urandom_range(1, 40);
            reg_end = $urandom_range(0, n);
            b       = 1'($urandom_range(0, 1));
            for (int j = 0; j < n; j++) begin
                if ($urandom_range(0, 3) == 0) b = !b;
                fb[j] = b;
                fe[j] = (j < reg_end);
            end
            run_frame("random", n);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_underrun();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/can_bit_stuffer.md
Name: can_bit_stuffer

Overview:
Transmit-side CAN bit stuffer. It sits between the frame serializer and the bus driver. It accepts unstuffed frame bits through a valid/ready handshake, one per bit time. After STUFF_LEN consecutive equal bits inside the stuffing region it inserts one complementary stuff bit, then drives the resulting stream onto tx_bit. It is the inserting counterpart of the receive/monitor-side bit-stuff detector.

Parameters:
STUFF_LEN, 5, run length of equal bits that triggers insertion of one stuff bit (legal range 2..15)

Ports:
clock  input  1  system clock; all state updates on posedge
reset  input  1  asynchronous, active-high reset
bit_tick  input  1  one-clock pulse per CAN bit time (transmit point)
frame_start  input  1  one-clock pulse; arms a new frame and clears run history
in_valid  input  1  serializer has a bit on in_bit
in_bit  input  1  unstuffed frame bit (0 = dominant, 1 = recessive)
in_stuff_en  input  1  qualifies in_bit as inside the stuffing region (SOF..CRC)
in_last  input  1  in_bit is the final bit of the frame
in_ready  output  1  stuffer will accept in_bit on the next bit_tick
tx_bit  output  1  stuffed bit stream to bus driver
tx_stuff  output  1  high while tx_bit is an inserted stuff bit
busy  output  1  frame in progress (state != IDLE)
underrun  output  1  one-clock pulse: bit_tick in DATA with no bit available

Behaviour:
- Reset (async, immediate): tx_bit=1 (recessive), tx_stuff=0, in_ready=0, busy=0, underrun=0, state=IDLE, run count=0, last_bit=1, stuff_pending=0, last_seen=0.
- States: IDLE, DATA, STUFF.
- All outputs are registered. in_ready = (state==DATA) && !stuff_pending.
- Transfer occurs only when bit_tick && in_valid && in_ready. tx_bit and tx_stuff update one clock after that bit_tick.
- IDLE: tx_bit=1 and tx_stuff=0. frame_start moves the block to DATA and clears count, pending and last_seen. bit_tick is ignored.
- DATA, on bit_tick with a transfer:
  - tx_bit=in_bit, tx_stuff=0.
  - If in_stuff_en=1: count becomes count+1 when in_bit==last_bit and count!=0, otherwise count becomes 1; last_bit=in_bit.
  - If the new count==STUFF_LEN: stuff_pending=1 and the next state is STUFF.
  - If in_stuff_en=0: count=0 and no stuff bit is generated.
  - If in_last=1: latch last_seen. With no stuff pending, go to IDLE after this bit.
- DATA, on bit_tick with in_valid=0: tx_bit=1, pulse underrun, abort to IDLE, clear count.
- STUFF, on the next bit_tick: tx_bit=~last_bit, tx_stuff=1.
  - last_bit=~last_bit, count=1, stuff_pending=0.
  - Go to IDLE if last_seen, else return to DATA.
  - in_valid is ignored during this bit time.
- Stuff bits start a new run; a stuff bit followed by STUFF_LEN-1 equal bits triggers another stuff bit.
- A pending stuff bit is always emitted, even if in_stuff_en or in_last accompanied the completing bit. This allows a stuff bit after the last CRC bit.
- frame_start in DATA/STUFF: restart. Go to DATA, clear count, pending and last_seen, tx_stuff=0. frame_start takes priority over a simultaneous bit_tick.
- Count width: $clog2(STUFF_LEN+1). The count never exceeds STUFF_LEN.

Optional Feature:
CAN_STUFF_CNT_EN defined:
- Adds output stuff_count[7:0].
- stuff_count is cleared by reset and by frame_start.
- It increments on each emitted stuff bit and saturates at 255.

Without CAN_STUFF_CNT_EN: the port and counter are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package def.pkg: enum typedef can_stuff_state_t {IDLE, DATA, STUFF}; constants CAN_DOMINANT=1'b0, CAN_RECESSIVE=1'b1, CAN_STUFF_LEN=5.
- Sub-module can_run_counter: tracks last_bit and run count, and outputs a hit flag at threshold. Inputs: bit, qualify, load-stuff, clear.

Test Plan:
- frame_start; send 0,0,0,0,0,1 with in_stuff_en=1 -> tx_bit 0,0,0,0,0,1(tx_stuff=1),1. in_ready low for exactly one bit time.
- Send 0×5, then 1,1,1,1 (in_stuff_en=1) -> 00000, stuff 1, 1111, stuff 0. Two stuff pulses total.
- Send 0×7 with in_stuff_en=0 -> seven 0s, tx_stuff never asserts, count stays 0.
- Send 1×5 with in_last on the 5th bit -> 11111, stuff 0, then busy=0 and tx_bit=1 at the next tick.
- In DATA, drop in_valid at a bit_tick -> underrun pulses one clock, tx_bit=1, state IDLE.
- Assert reset mid-stuff-run (after 3 zeros) -> outputs reset immediately. After frame_start, 0×4 produces no stuff bit. With CAN_STUFF_CNT_EN, stuff_count reads 0 after reset and 2 after the second scenario.
